// File: rtl/control_unit.sv
// Purpose : multi-cycle Moore sequencer for the 8-bit edulent CPU; drives PC/IR/SP/A/memory strobes.
// Latency : FETCH+DECODE+EX; NOP/LDA/ADD_A/JMP 3 cycles, RET 4, CALL 5; next_instr marks retirement.
// Backpressure: none; memory is assumed single-cycle, so the sequencer never stalls.
//
// Ports:
//   i_clk, i_rstn            clock (rising edge), asynchronous active-low reset
//   i_opcode[7:0]            IR contents, sampled only in DECODE
//   o_ir_load, o_mem_rd,     IR load, memory read strobe,
//   o_mem_wr                 memory write strobe (write data = PC)
//   o_addr_sel[1:0]          address mux: 00=PC 01=SP 10=TMP
//   o_pc_inc, o_pc_load,     PC increment, PC load,
//   o_pc_src                 PC load source: 0=data bus, 1=TMP
//   o_tmp_load, o_a_load,    TMP load, A load,
//   o_alu_add                ALU add with flag update
//   o_sp_inc, o_sp_dec       stack pointer adjust (stack grows down, SP = next free slot)
//   o_halted, o_illegal      halt status, illegal-opcode trap status
//   next_instr               one-cycle pulse in the final cycle of each instruction
//
// Configuration macro: CONTROL_UNIT_ILLEGAL_TRAP_EN
//   defined     : undecoded opcode halts with o_illegal=1, no next_instr pulse
//   not defined : undecoded opcode behaves as NOP, o_illegal tied 0

module control_unit (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [7:0] i_opcode,
    output logic       o_ir_load,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic [1:0] o_addr_sel,
    output logic       o_pc_inc,
    output logic       o_pc_load,
    output logic       o_pc_src,
    output logic       o_tmp_load,
    output logic       o_a_load,
    output logic       o_alu_add,
    output logic       o_sp_inc,
    output logic       o_sp_dec,
    output logic       o_halted,
    output logic       o_illegal,
    output logic       next_instr
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LDA   = 8'h10;
    localparam logic [7:0] OP_ADD_A = 8'h20;
    localparam logic [7:0] OP_JMP   = 8'h80;
    localparam logic [7:0] OP_RET   = 8'hB0;
    localparam logic [7:0] OP_CALL  = 8'hC1;
    localparam logic [7:0] OP_HLT   = 8'hFF;

    localparam logic [1:0] ADDR_PC  = 2'b00;
    localparam logic [1:0] ADDR_SP  = 2'b01;

    typedef enum logic [2:0] {
        RST_IDLE = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EX1      = 3'd3,
        EX2      = 3'd4,
        EX3      = 3'd5,
        HALT     = 3'd6
    } state_t;

    state_t     state_q,    state_d;
    logic [7:0] opcode_q,   opcode_d;
    // Set after the first HALT cycle so the HLT retirement pulse is one cycle wide.
    logic       halt_ack_q, halt_ack_d;

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    function automatic logic is_decoded(input logic [7:0] op);
        case (op)
            OP_NOP, OP_LDA, OP_ADD_A, OP_JMP,
            OP_RET, OP_CALL, OP_HLT:         is_decoded = 1'b1;
            default:                         is_decoded = 1'b0;
        endcase
    endfunction
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= RST_IDLE;
            opcode_q   <= OP_NOP;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        halt_ack_d = halt_ack_q;

        case (state_q)
            RST_IDLE: state_d = FETCH;

            FETCH:    state_d = DECODE;

            DECODE: begin
                // Only point where the IR is observed; later IR changes are ignored.
                opcode_d   = i_opcode;
                halt_ack_d = 1'b0;
                if (i_opcode == OP_HLT) begin
                    state_d = HALT;
                end
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
                else if (!is_decoded(i_opcode)) begin
                    state_d = HALT;
                end
`endif
                else begin
                    state_d = EX1;
                end
            end

            EX1: begin
                if (opcode_q == OP_CALL || opcode_q == OP_RET) begin
                    state_d = EX2;
                end else begin
                    // NOP, LDA, ADD_A, JMP and (untrapped) undecoded opcodes retire here.
                    state_d = FETCH;
                end
            end

            EX2: begin
                if (opcode_q == OP_CALL) begin
                    state_d = EX3;
                end else begin
                    state_d = FETCH;
                end
            end

            EX3:      state_d = FETCH;

            HALT: begin
                // Sticky until reset.
                state_d    = HALT;
                halt_ack_d = 1'b1;
            end

            default:  state_d = RST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs: function of state_q, opcode_q and the halt pulse flag
    // ------------------------------------------------------------------
    always_comb begin
        o_ir_load  = 1'b0;
        o_mem_rd   = 1'b0;
        o_mem_wr   = 1'b0;
        o_addr_sel = ADDR_PC;
        o_pc_inc   = 1'b0;
        o_pc_load  = 1'b0;
        o_pc_src   = 1'b0;
        o_tmp_load = 1'b0;
        o_a_load   = 1'b0;
        o_alu_add  = 1'b0;
        o_sp_inc   = 1'b0;
        o_sp_dec   = 1'b0;
        o_halted   = 1'b0;
        o_illegal  = 1'b0;
        next_instr = 1'b0;

        case (state_q)
            FETCH: begin
                o_mem_rd   = 1'b1;
                o_addr_sel = ADDR_PC;
                o_ir_load  = 1'b1;
                o_pc_inc   = 1'b1;
            end

            EX1: begin
                case (opcode_q)
                    OP_LDA: begin
                        // Immediate operand sits at PC; step past it.
                        o_mem_rd   = 1'b1;
                        o_addr_sel = ADDR_PC;
                        o_a_load   = 1'b1;
                        o_pc_inc   = 1'b1;
                        next_instr = 1'b1;
                    end
                    OP_ADD_A: begin
                        o_alu_add  = 1'b1;
                        o_a_load   = 1'b1;
                        next_instr = 1'b1;
                    end
                    OP_JMP: begin
                        o_mem_rd   = 1'b1;
                        o_addr_sel = ADDR_PC;
                        o_pc_load  = 1'b1;
                        o_pc_src   = 1'b0;
                        next_instr = 1'b1;
                    end
                    OP_CALL: begin
                        // Target goes to TMP; PC advances so it becomes the return address.
                        o_mem_rd   = 1'b1;
                        o_addr_sel = ADDR_PC;
                        o_tmp_load = 1'b1;
                        o_pc_inc   = 1'b1;
                    end
                    OP_RET: begin
                        // SP points at the free slot; step up to the saved return address.
                        o_sp_inc   = 1'b1;
                    end
                    default: begin
                        // NOP and undecoded opcodes that were not trapped.
                        next_instr = 1'b1;
                    end
                endcase
            end

            EX2: begin
                if (opcode_q == OP_CALL) begin
                    o_mem_wr   = 1'b1;
                    o_addr_sel = ADDR_SP;
                    o_sp_dec   = 1'b1;
                end else if (opcode_q == OP_RET) begin
                    o_mem_rd   = 1'b1;
                    o_addr_sel = ADDR_SP;
                    o_pc_load  = 1'b1;
                    o_pc_src   = 1'b0;
                    next_instr = 1'b1;
                end
            end

            EX3: begin
                if (opcode_q == OP_CALL) begin
                    o_pc_load  = 1'b1;
                    o_pc_src   = 1'b1;
                    next_instr = 1'b1;
                end
            end

            HALT: begin
                o_halted = 1'b1;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
                if (opcode_q != OP_HLT) begin
                    o_illegal = 1'b1;
                end else begin
                    next_instr = !halt_ack_q;
                end
`else
                next_instr = !halt_ack_q;
`endif
            end

            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Purpose : scoreboard bench for control_unit; directed opcode sequences with hand-computed strobes.
// Latency : one expected output vector per clock, compared on the falling edge.
// Backpressure: none; a cycle-tagged queue decouples stimulus from the monitor.

module tb_control_unit;

    logic       i_clk;
    logic       i_rstn;
    logic [7:0] i_opcode;
    logic       o_ir_load, o_mem_rd, o_mem_wr;
    logic [1:0] o_addr_sel;
    logic       o_pc_inc, o_pc_load, o_pc_src, o_tmp_load, o_a_load, o_alu_add;
    logic       o_sp_inc, o_sp_dec, o_halted, o_illegal, next_instr;

    control_unit dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_opcode   (i_opcode),
        .o_ir_load  (o_ir_load),
        .o_mem_rd   (o_mem_rd),
        .o_mem_wr   (o_mem_wr),
        .o_addr_sel (o_addr_sel),
        .o_pc_inc   (o_pc_inc),
        .o_pc_load  (o_pc_load),
        .o_pc_src   (o_pc_src),
        .o_tmp_load (o_tmp_load),
        .o_a_load   (o_a_load),
        .o_alu_add  (o_alu_add),
        .o_sp_inc   (o_sp_inc),
        .o_sp_dec   (o_sp_dec),
        .o_halted   (o_halted),
        .o_illegal  (o_illegal),
        .next_instr (next_instr)
    );

    // Output vector bit positions.
    localparam logic [15:0] IR   = 16'h8000;
    localparam logic [15:0] RD   = 16'h4000;
    localparam logic [15:0] WR   = 16'h2000;
    localparam logic [15:0] ATMP = 16'h1000;  // addr_sel = 10
    localparam logic [15:0] ASP  = 16'h0800;  // addr_sel = 01
    localparam logic [15:0] PCI  = 16'h0400;
    localparam logic [15:0] PCL  = 16'h0200;
    localparam logic [15:0] PCS  = 16'h0100;
    localparam logic [15:0] TMP  = 16'h0080;
    localparam logic [15:0] AL   = 16'h0040;
    localparam logic [15:0] ALU  = 16'h0020;
    localparam logic [15:0] SPI  = 16'h0010;
    localparam logic [15:0] SPD  = 16'h0008;
    localparam logic [15:0] HLTD = 16'h0004;
    localparam logic [15:0] ILL  = 16'h0002;
    localparam logic [15:0] NI   = 16'h0001;
    localparam logic [15:0] NONE = 16'h0000;

    localparam logic [15:0] E_FETCH = IR | RD | PCI;
    localparam logic [15:0] E_NOP   = NI;
    localparam logic [15:0] E_LDA   = RD | AL | PCI | NI;
    localparam logic [15:0] E_ADD   = ALU | AL | NI;
    localparam logic [15:0] E_JMP   = RD | PCL | NI;
    localparam logic [15:0] E_CALL1 = RD | TMP | PCI;
    localparam logic [15:0] E_CALL2 = WR | ASP | SPD;
    localparam logic [15:0] E_CALL3 = PCL | PCS | NI;
    localparam logic [15:0] E_RET1  = SPI;
    localparam logic [15:0] E_RET2  = RD | ASP | PCL | NI;

    logic [15:0] out_vec;
    assign out_vec = {o_ir_load, o_mem_rd, o_mem_wr, o_addr_sel, o_pc_inc, o_pc_load,
                      o_pc_src, o_tmp_load, o_a_load, o_alu_add, o_sp_inc, o_sp_dec,
                      o_halted, o_illegal, next_instr};

    typedef struct {
        int          cyc;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   total;
    int   bad;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Monitor: every falling edge, compare the entry tagged for this cycle.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            if (exp_q[0].cyc == cyc) begin
                total = total + 1;
                if (out_vec !== exp_q[0].exp) begin
                    bad = bad + 1;
                    $display("FAIL %s cyc=%0d got=%h want=%h", exp_q[0].name, cyc,
                             out_vec, exp_q[0].exp);
                end
                void'(exp_q.pop_front());
            end else if (exp_q[0].cyc < cyc) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL %s missed cyc=%0d got=%h want=%h", exp_q[0].name,
                         exp_q[0].cyc, out_vec, exp_q[0].exp);
                void'(exp_q.pop_front());
            end
        end
    end

    // One clock: drive opcode just after the edge and queue the expected outputs
    // for the state entered on that edge.
    task automatic step(input logic [7:0] op, input logic [15:0] e, input string nm);
        exp_t t;
        @(posedge i_clk);
        #1;
        i_opcode = op;
        t.cyc  = cyc;
        t.exp  = e;
        t.name = nm;
        exp_q.push_back(t);
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        step(8'hC1, NONE, "rst_hold");
        step(8'hC1, NONE, "rst_hold");
        step(8'hC1, NONE, "rst_idle");
        i_rstn = 1'b1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        i_rstn   = 1'b0;
        i_opcode = 8'hC1;

        // Reset held with CALL on the IR, then released: CALL retires in the 6th cycle.
        do_reset();
        step(8'hC1, E_FETCH, "call_fetch");
        step(8'hC1, NONE,    "call_decode");
        step(8'h00, E_CALL1, "call_ex1");
        step(8'h00, E_CALL2, "call_ex2");
        step(8'h00, E_CALL3, "call_ex3");

        // RET after CALL.
        step(8'h00, E_FETCH, "ret_fetch");
        step(8'hB0, NONE,    "ret_decode");
        step(8'h20, E_RET1,  "ret_ex1");
        step(8'h10, E_RET2,  "ret_ex2");

        // NOP/LDA/ADD_A/JMP back to back; IR altered after DECODE each time.
        step(8'h00, E_FETCH, "nop_fetch");
        step(8'h00, NONE,    "nop_decode");
        step(8'hC1, E_NOP,   "nop_ex1");
        step(8'h00, E_FETCH, "lda_fetch");
        step(8'h10, NONE,    "lda_decode");
        step(8'h20, E_LDA,   "lda_ex1");
        step(8'h00, E_FETCH, "add_fetch");
        step(8'h20, NONE,    "add_decode");
        step(8'hFF, E_ADD,   "add_ex1");
        step(8'h00, E_FETCH, "jmp_fetch");
        step(8'h80, NONE,    "jmp_decode");
        step(8'hB0, E_JMP,   "jmp_ex1");

        // Async reset asserted mid-cycle in CALL EX2: outputs drop before the next edge.
        step(8'h00, E_FETCH, "call2_fetch");
        step(8'hC1, NONE,    "call2_decode");
        step(8'h00, E_CALL1, "call2_ex1");
        step(8'h00, NONE,    "call2_ex2_rst");
        #2;
        i_rstn = 1'b0;
        do_reset();

        // Undecoded opcode 8'h42.
        step(8'h00, E_FETCH, "ill_fetch");
        step(8'h42, NONE,    "ill_decode");
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
        step(8'h00, HLTD | ILL, "ill_halt0");
        step(8'h00, HLTD | ILL, "ill_halt1");
        step(8'h00, HLTD | ILL, "ill_halt2");
`else
        step(8'h00, E_NOP,   "ill_as_nop");
        step(8'h00, E_FETCH, "ill_next_fetch");
        step(8'h00, NONE,    "ill_next_decode");
`endif
        do_reset();

        // HLT: single retirement pulse, then halted until reset.
        step(8'h00, E_FETCH,   "hlt_fetch");
        step(8'hFF, NONE,      "hlt_decode");
        step(8'h00, HLTD | NI, "hlt_entry");
        step(8'h00, HLTD,      "hlt_hold1");
        step(8'h10, HLTD,      "hlt_hold2");
        step(8'hC1, HLTD,      "hlt_hold3");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge i_clk);
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
